// File: rtl/simd_loop_replay_ctrl.sv
// Issue stage ahead of the SIMD iterator address generator: registered passthrough,
// loop-body capture and in-place replay. Optional replay counter under SIMD_LOOP_PERF_CNT_EN.
module simd_loop_replay_ctrl #(
    parameter int NS_ID_BITS       = 3,
    parameter int NS_INDEX_ID_BITS = 5,
    parameter int OPCODE_BITS      = 4,
    parameter int FUNCTION_BITS    = 4,
    parameter int INST_WIDTH       = 32,
    parameter int MAX_BODY         = 16,
    parameter int BODY_ADDR_BITS   = 4,
    parameter int LOOP_CNT_BITS    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inst_valid,
    input  logic [INST_WIDTH-1:0]       inst_data,
    output logic                        inst_ready,
    output logic                        out_valid,
    output logic [OPCODE_BITS-1:0]      opcode,
    output logic [FUNCTION_BITS-1:0]    fn,
    output logic [NS_ID_BITS-1:0]       dest_ns_id,
    output logic [NS_INDEX_ID_BITS-1:0] dest_ns_index_id,
    output logic [NS_ID_BITS-1:0]       src1_ns_id,
    output logic [NS_INDEX_ID_BITS-1:0] src1_ns_index_id,
    output logic [NS_ID_BITS-1:0]       src2_ns_id,
    output logic [NS_INDEX_ID_BITS-1:0] src2_ns_index_id,
    output logic                        in_single_loop,
    output logic                        loop_done,
    output logic [LOOP_CNT_BITS-1:0]    iter_count,
    output logic                        loop_err
`ifdef SIMD_LOOP_PERF_CNT_EN
    ,
    output logic [31:0]                 replay_count
`endif
);

    // state   | meaning
    // PASS    | forward instructions, decode loop config
    // CAPTURE | forward and record the first pass of the loop body
    // REPLAY  | reissue the recorded body from the buffer, upstream stalled

    localparam int BL_W    = BODY_ADDR_BITS + 1;
    localparam int OP_LSB  = INST_WIDTH - OPCODE_BITS;
    localparam int FN_LSB  = OP_LSB - FUNCTION_BITS;
    localparam int DID_LSB = FN_LSB - NS_ID_BITS;
    localparam int DIX_LSB = DID_LSB - NS_INDEX_ID_BITS;
    localparam int S1D_LSB = DIX_LSB - NS_ID_BITS;
    localparam int S1X_LSB = S1D_LSB - NS_INDEX_ID_BITS;
    localparam int S2D_LSB = S1X_LSB - NS_ID_BITS;
    localparam int S2X_LSB = S2D_LSB - NS_INDEX_ID_BITS;

    localparam logic [OPCODE_BITS-1:0]   LOOP_OPC = OPCODE_BITS'(4'b1001);
    localparam logic [FUNCTION_BITS-1:0] FN_SET   = FUNCTION_BITS'(0);
    localparam logic [FUNCTION_BITS-1:0] FN_BODY  = FUNCTION_BITS'(1);
    localparam logic [15:0]              MAX_BODY_W = 16'(MAX_BODY);

    typedef enum logic [1:0] {
        ST_PASS,
        ST_CAPTURE,
        ST_REPLAY
    } state_t;

    state_t                    state;
    logic [LOOP_CNT_BITS-1:0]  loop_total;
    logic [BL_W-1:0]           body_len;
    logic [BL_W-1:0]           wcnt;
    logic [BODY_ADDR_BITS-1:0] rptr;
    logic [INST_WIDTH-1:0]     body_buf [MAX_BODY];

    logic                      accept;
    logic                      is_set;
    logic                      is_body;
    logic                      is_cfg;
    logic [15:0]               imm;
    logic [BL_W-1:0]           body_last;
    logic                      issue_en;
    logic [INST_WIDTH-1:0]     issue_word;

    assign inst_ready = (state != ST_REPLAY);
    assign accept     = inst_valid && inst_ready;
    assign imm        = inst_data[15:0];
    assign is_set     = (inst_data[INST_WIDTH-1:OP_LSB] == LOOP_OPC) &&
                        (inst_data[OP_LSB-1:FN_LSB] == FN_SET);
    assign is_body    = (inst_data[INST_WIDTH-1:OP_LSB] == LOOP_OPC) &&
                        (inst_data[OP_LSB-1:FN_LSB] == FN_BODY);
    assign is_cfg     = is_set || is_body;
    assign body_last  = body_len - BL_W'(1);

    always_comb begin
        issue_en   = 1'b0;
        issue_word = inst_data;
        if (state == ST_REPLAY) begin
            issue_en   = 1'b1;
            issue_word = body_buf[rptr];
        end else if (accept && !is_cfg) begin
            issue_en = 1'b1;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE && accept && !is_cfg) begin
            body_buf[wcnt[BODY_ADDR_BITS-1:0]] <= inst_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_PASS;
            loop_total       <= '0;
            body_len         <= '0;
            wcnt             <= '0;
            rptr             <= '0;
            iter_count       <= '0;
            loop_err         <= 1'b0;
            loop_done        <= 1'b0;
            out_valid        <= 1'b0;
            in_single_loop   <= 1'b0;
            opcode           <= '0;
            fn               <= '0;
            dest_ns_id       <= '0;
            dest_ns_index_id <= '0;
            src1_ns_id       <= '0;
            src1_ns_index_id <= '0;
            src2_ns_id       <= '0;
            src2_ns_index_id <= '0;
        end else begin
            out_valid      <= issue_en;
            in_single_loop <= issue_en && (state == ST_REPLAY);
            loop_done      <= 1'b0;
            if (issue_en) begin
                opcode           <= issue_word[INST_WIDTH-1:OP_LSB];
                fn               <= issue_word[OP_LSB-1:FN_LSB];
                dest_ns_id       <= issue_word[FN_LSB-1:DID_LSB];
                dest_ns_index_id <= issue_word[DID_LSB-1:DIX_LSB];
                src1_ns_id       <= issue_word[DIX_LSB-1:S1D_LSB];
                src1_ns_index_id <= issue_word[S1D_LSB-1:S1X_LSB];
                src2_ns_id       <= issue_word[S1X_LSB-1:S2D_LSB];
                src2_ns_index_id <= issue_word[S2D_LSB-1:S2X_LSB];
            end

            case (state)
                ST_PASS: begin
                    iter_count <= '0;
                    if (accept && is_set) begin
                        loop_total <= (imm == 16'd0) ? LOOP_CNT_BITS'(1) : LOOP_CNT_BITS'(imm);
                    end else if (accept && is_body) begin
                        if (imm == 16'd0) begin
                            loop_done <= 1'b1;
                        end else begin
                            if (imm > MAX_BODY_W) begin
                                loop_err <= 1'b1;
                                body_len <= BL_W'(MAX_BODY);
                            end else begin
                                body_len <= imm[BL_W-1:0];
                            end
                            wcnt  <= '0;
                            state <= ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (accept && is_cfg) begin
                        loop_err <= 1'b1;
                    end else if (accept) begin
                        if (wcnt == body_last) begin
                            // A reset-default loop_total of 0 counts as a single pass.
                            if (loop_total <= LOOP_CNT_BITS'(1)) begin
                                loop_done <= 1'b1;
                                state     <= ST_PASS;
                            end else begin
                                iter_count <= LOOP_CNT_BITS'(1);
                                rptr       <= '0;
                                state      <= ST_REPLAY;
                            end
                        end else begin
                            wcnt <= wcnt + BL_W'(1);
                        end
                    end
                end

                ST_REPLAY: begin
                    if ({1'b0, rptr} == body_last) begin
                        rptr <= '0;
                        if (iter_count == loop_total - LOOP_CNT_BITS'(1)) begin
                            loop_done <= 1'b1;
                            state     <= ST_PASS;
                        end else begin
                            iter_count <= iter_count + LOOP_CNT_BITS'(1);
                        end
                    end else begin
                        rptr <= rptr + BODY_ADDR_BITS'(1);
                    end
                end

                default: state <= ST_PASS;
            endcase
        end
    end

`ifdef SIMD_LOOP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            replay_count <= '0;
        end else if (state == ST_REPLAY && replay_count != 32'hFFFF_FFFF) begin
            replay_count <= replay_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simd_loop_replay_ctrl.sv
// Bench for simd_loop_replay_ctrl: directed scenarios plus random loops against a
// per-cycle expected-output queue built from the loop rules.
module tb_simd_loop_replay_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_data = '0;
    logic        inst_ready, out_valid, in_single_loop, loop_done, loop_err;
    logic [3:0]  opcode, fn;
    logic [2:0]  dest_ns_id, src1_ns_id, src2_ns_id;
    logic [4:0]  dest_ns_index_id, src1_ns_index_id, src2_ns_index_id;
    logic [15:0] iter_count;
`ifdef SIMD_LOOP_PERF_CNT_EN
    logic [31:0] replay_count;
`endif

    always #5 clk = ~clk;

    simd_loop_replay_ctrl dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_ready(inst_ready), .out_valid(out_valid), .opcode(opcode), .fn(fn),
        .dest_ns_id(dest_ns_id), .dest_ns_index_id(dest_ns_index_id),
        .src1_ns_id(src1_ns_id), .src1_ns_index_id(src1_ns_index_id),
        .src2_ns_id(src2_ns_id), .src2_ns_index_id(src2_ns_index_id),
        .in_single_loop(in_single_loop), .loop_done(loop_done),
        .iter_count(iter_count), .loop_err(loop_err)
`ifdef SIMD_LOOP_PERF_CNT_EN
        , .replay_count(replay_count)
`endif
    );

    typedef struct {
        bit          valid;
        bit          isl;
        bit          done;
        bit          chkf;
        logic [31:0] inst;
        int          iter;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] cap[$];
    int          total = 0;
    int          bad = 0;
    int          m_total;
    int          m_body;
    bit          m_capturing;
    bit          m_err;
    longint      m_rc;

    function automatic exp_t mk(bit v, bit isl, bit done, bit chkf, logic [31:0] d, int it);
        exp_t e;
        e.valid = v; e.isl = isl; e.done = done; e.chkf = chkf; e.inst = d; e.iter = it;
        return e;
    endfunction

    function automatic logic [31:0] cfg(input logic [3:0] f, input logic [15:0] imm);
        return {4'h9, f, 8'h00, imm};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] d;
        d = $urandom;
        if (d[31:28] == 4'h9) d[31:28] = 4'h2;
        return d;
    endfunction

    function automatic bit model_ready();
        return !(expq.size() > 0 && expq[0].isl);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow from the loop rules: one forwarded copy per captured
    // instruction, then (total-1) replayed passes of the body.
    task automatic model_accept(input logic [31:0] d);
        bit set_i, body_i;
        int imm;
        set_i  = (d[31:28] == 4'h9) && (d[27:24] == 4'h0);
        body_i = (d[31:28] == 4'h9) && (d[27:24] == 4'h1);
        imm    = int'(d[15:0]);
        if (!m_capturing) begin
            if (set_i) begin
                m_total = (imm == 0) ? 1 : imm;
            end else if (body_i) begin
                if (imm == 0) begin
                    expq.push_back(mk(0, 0, 1, 0, 0, 0));
                end else begin
                    if (imm > 16) m_err = 1;
                    m_body = (imm > 16) ? 16 : imm;
                    m_capturing = 1;
                    cap.delete();
                end
            end else begin
                expq.push_back(mk(1, 0, 0, 0, d, 0));
            end
        end else if (set_i || body_i) begin
            m_err = 1;
        end else begin
            cap.push_back(d);
            if (cap.size() < m_body) begin
                expq.push_back(mk(1, 0, 0, 0, d, 0));
            end else begin
                m_capturing = 0;
                if (m_total <= 1) begin
                    expq.push_back(mk(1, 0, 1, 0, d, 0));
                end else begin
                    expq.push_back(mk(1, 0, 0, 0, d, 1));
                    for (int p = 1; p < m_total; p++) begin
                        for (int k = 0; k < m_body; k++) begin
                            bool_push(p, k);
                        end
                    end
                end
            end
        end
    endtask

    task automatic bool_push(input int p, input int k);
        bit last_pass, last_k;
        int it;
        last_pass = (p == m_total - 1);
        last_k    = (k == m_body - 1);
        it = (last_k && !last_pass) ? p + 1 : p;
        expq.push_back(mk(1, 1, last_pass && last_k, 0, cap[k], it));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() > 0) e = expq.pop_front();
        else e = mk(0, 0, 0, 0, 0, 0);
        if (e.isl) m_rc++;
        chk("out_valid", out_valid, e.valid);
        chk("in_single_loop", in_single_loop, e.isl);
        chk("loop_done", loop_done, e.done);
        chk("loop_err", loop_err, m_err);
        if (e.iter >= 0) chk("iter_count", iter_count, e.iter);
        if (e.valid || e.chkf)
            chk("fields", {opcode, fn, dest_ns_id, dest_ns_index_id, src1_ns_id,
                           src1_ns_index_id, src2_ns_id, src2_ns_index_id}, e.inst);
`ifdef SIMD_LOOP_PERF_CNT_EN
        chk("replay_count", replay_count, m_rc[31:0]);
`endif
    endtask

    task automatic send(input logic [31:0] d);
        bit rdy;
        rdy = model_ready();
        inst_valid = 1'b1;
        inst_data  = d;
        chk("inst_ready", inst_ready, rdy);
        if (rdy) model_accept(d);
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic idle();
        inst_valid = 1'b0;
        chk("inst_ready_idle", inst_ready, model_ready());
        tick();
    endtask

    // Replay stalls upstream; garbage held on the input must be ignored meanwhile.
    task automatic drain();
        int guard = 0;
        while (expq.size() > 0 && guard < 2000) begin
            if ($urandom_range(1) == 1) send(rand_inst());
            else idle();
            guard++;
        end
        if (guard >= 2000) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_valid = 1'b0;
        expq.delete();
        cap.delete();
        m_total = 0; m_body = 0; m_capturing = 0; m_err = 0; m_rc = 0;
        expq.push_back(mk(0, 0, 0, 1, 0, 0));
        tick();
        reset = 1'b0;
        chk("inst_ready_after_reset", inst_ready, 1);
    endtask

    initial begin
        do_reset();

        send(32'h2123_4567);
        send(32'h1000_1111);
        idle();

        send(cfg(4'h0, 16'd3));
        send(cfg(4'h1, 16'd2));
        send(32'hA000_0001);
        send(32'h3000_0002);
        drain();
        idle();

        send(cfg(4'h0, 16'd0));
        send(cfg(4'h1, 16'd1));
        send(32'h5555_AAAA);
        idle();

        send(cfg(4'h1, 16'd0));
        idle();
        idle();

        send(cfg(4'h0, 16'd2));
        send(cfg(4'h1, 16'd20));
        for (int i = 0; i < 16; i++) begin
            if (i == 5) send(cfg(4'h0, 16'd7));
            send(rand_inst());
        end
        drain();
        idle();

        do_reset();
        send(cfg(4'h0, 16'd5));
        send(cfg(4'h1, 16'd3));
        for (int i = 0; i < 3; i++) send(rand_inst());
        for (int i = 0; i < 4; i++) idle();
        do_reset();
        idle();

        for (int n = 0; n < 30; n++) begin
            int b, pre;
            pre = $urandom_range(3);
            for (int i = 0; i < pre; i++) send(rand_inst());
            if ($urandom_range(3) != 0) send(cfg(4'h0, 16'($urandom_range(5))));
            if ($urandom_range(7) == 0) b = $urandom_range(30, 17);
            else b = $urandom_range(6);
            send(cfg(4'h1, 16'(b)));
            if (b > 16) b = 16;
            for (int k = 0; k < b; k++) begin
                if ($urandom_range(3) == 0) idle();
                if ($urandom_range(9) == 0) send(cfg(4'($urandom_range(1)), 16'($urandom_range(9))));
                send(rand_inst());
            end
            drain();
            if ($urandom_range(1) == 1) idle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simd_loop_replay_ctrl.md
Name: simd_loop_replay_ctrl

Overview:
- Instruction-issue stage directly upstream of the SIMD iterator address generator.
- Passes ordinary SIMD instructions through with one cycle of registered latency.
- Decodes loop-configuration instructions, captures the loop body into a small buffer and replays it without re-fetching.
- Drives in_single_loop so the downstream stage writes base+stride back into the iterator table on every replayed pass.

Parameters:
- NS_ID_BITS, 3, namespace id width
- NS_INDEX_ID_BITS, 5, namespace index width
- OPCODE_BITS, 4, opcode width
- FUNCTION_BITS, 4, function field width
- INST_WIDTH, 32, instruction width
- MAX_BODY, 16, loop body buffer depth in instructions
- BODY_ADDR_BITS, 4, log2(MAX_BODY)
- LOOP_CNT_BITS, 16, iteration counter width

Ports:
- clk in 1: clock
- reset in 1: synchronous, active-high reset
- inst_valid in 1: upstream instruction valid
- inst_data in INST_WIDTH: [31:28] opcode, [27:24] fn, [23:21] dest_ns_id, [20:16] dest_ns_index_id, [15:13] src1_ns_id, [12:8] src1_ns_index_id, [7:5] src2_ns_id, [4:0] src2_ns_index_id
- inst_ready out 1: instruction accepted when inst_valid && inst_ready
- out_valid out 1: issued-instruction valid
- opcode out OPCODE_BITS: issued opcode
- fn out FUNCTION_BITS: issued function field
- dest_ns_id out NS_ID_BITS: issued dest namespace id
- dest_ns_index_id out NS_INDEX_ID_BITS: issued dest namespace index
- src1_ns_id out NS_ID_BITS: issued src1 namespace id
- src1_ns_index_id out NS_INDEX_ID_BITS: issued src1 namespace index
- src2_ns_id out NS_ID_BITS: issued src2 namespace id
- src2_ns_index_id out NS_INDEX_ID_BITS: issued src2 namespace index
- in_single_loop out 1: high with out_valid for every replayed instruction
- loop_done out 1: one-cycle pulse when a loop completes
- iter_count out LOOP_CNT_BITS: current zero-based iteration
- loop_err out 1: sticky error flag, cleared only by reset

Behaviour:
- Reset values: all outputs 0; FSM in PASS; all counters 0.
- Loop-config instructions have opcode 4'b1001 and imm16 = inst_data[15:0].
  - fn 4'b0000 = LOOP_SET: loop_total <= imm16; 0 is treated as 1.
  - fn 4'b0001 = LOOP_BODY: body_len <= imm16.
  - Loop-config instructions are consumed and never forwarded.
- PASS state:
  - inst_ready = 1.
  - A non-loop instruction is registered to the outputs the next cycle with out_valid = 1 and in_single_loop = 0.
  - LOOP_BODY with body_len = 0: pulse loop_done next cycle, stay in PASS.
  - LOOP_BODY with body_len > MAX_BODY: clamp body_len to MAX_BODY, set loop_err, then proceed as below.
  - LOOP_BODY with body_len > 0: go to CAPTURE, clear the write pointer and iter_count.
- CAPTURE state:
  - inst_ready = 1.
  - Each accepted instruction is written to buf[wptr] and forwarded exactly as in PASS (first pass, in_single_loop = 0).
  - A loop-config instruction received in CAPTURE (nesting) is dropped, not stored, not counted, and sets loop_err.
  - On the body_len-th capture:
    - loop_total = 1: pulse loop_done with that instruction's out_valid, return to PASS.
    - otherwise: go to REPLAY, set iter_count = 1, set rptr = 0.
- REPLAY state:
  - inst_ready = 0.
  - Each cycle, buf[rptr] is issued with out_valid = 1 and in_single_loop = 1.
  - When rptr = body_len-1: rptr wraps to 0 and iter_count increments.
  - On the last instruction of iteration loop_total-1: loop_done pulses in the same cycle as that instruction, FSM returns to PASS, iter_count clears the following cycle.
- General rules:
  - No downstream backpressure; one instruction is issued per cycle maximum.
  - Output latency: 1 cycle from acceptance in PASS/CAPTURE; back-to-back issue in REPLAY.
  - A LOOP_SET in PASS takes effect for the next LOOP_BODY only. A LOOP_SET and a LOOP_BODY on consecutive cycles is legal.
  - Reset asserted mid-loop: immediate return to PASS, buffer contents don't-care, no loop_done pulse.
  - iter_count is LOOP_CNT_BITS wide and cannot overflow, because loop_total is at most 2^16-1.

Optional Feature:
- Macro SIMD_LOOP_PERF_CNT_EN.
- Defined: adds output port replay_count [31:0].
  - Increments once per instruction issued with in_single_loop = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Passthrough: instructions 32'h2123_4567 and 32'h1000_1111 in consecutive cycles -> the same fields appear on the outputs 1 cycle later, out_valid = 1, in_single_loop = 0, no loop_done.
- Basic loop: LOOP_SET 3, LOOP_BODY 2, then I0, I1 -> issue order I0, I1 (in_single_loop = 0), then I0, I1, I0, I1 (in_single_loop = 1, inst_ready = 0); loop_done coincides with the final I1; iter_count reads 1 then 2.
- Single iteration: LOOP_SET 0, LOOP_BODY 1, then I0 -> I0 is issued once with in_single_loop = 0, loop_done pulses with it, FSM is back in PASS with no REPLAY cycles.
- Zero body: LOOP_BODY 0 -> loop_done pulses the next cycle, nothing is issued, inst_ready stays 1.
- Errors: LOOP_BODY 20 -> clamped to 16, loop_err = 1. A LOOP_SET issued during CAPTURE -> dropped, not counted, loop_err stays 1 until reset.
- Reset mid-REPLAY: assert reset during iteration 2 of a 5-iteration loop -> next cycle all outputs 0, inst_ready = 1, no loop_done. With SIMD_LOOP_PERF_CNT_EN defined, replay_count = 0.
